// File: rtl/wb_regfile.sv
// MIPS write-back register file: 32 GPRs plus HI/LO, committed from MEM/WB.
// Reads are combinational with same-cycle bypass of the write being presented.
module wb_regfile #(
   parameter int REG_NUM = 32,
   parameter int DATA_W  = 32,
   localparam int AW     = $clog2(REG_NUM)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we,
   input  logic [AW-1:0]     wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              wb_hilo_we,
   input  logic [DATA_W-1:0] wb_hi,
   input  logic [DATA_W-1:0] wb_lo,
   input  logic              re1,
   input  logic [AW-1:0]     raddr1,
   input  logic              re2,
   input  logic [AW-1:0]     raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   logic [DATA_W-1:0] regs [REG_NUM];
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;

   // Whole file clears asynchronously, so storage is flops rather than block RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs[i] <= '0;
         end
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (wb_we && (wb_waddr != '0)) begin
            regs[wb_waddr] <= wb_wdata;
         end
         if (wb_hilo_we) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
         end
      end
   end

   logic              re_v    [2];
   logic [AW-1:0]     raddr_v [2];
   logic [DATA_W-1:0] rdata_v [2];

   assign re_v[0]    = re1;
   assign re_v[1]    = re2;
   assign raddr_v[0] = raddr1;
   assign raddr_v[1] = raddr2;
   assign rdata1     = rdata_v[0];
   assign rdata2     = rdata_v[1];

   // Each read port resolves independently; $0 always reads zero.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         assign rdata_v[gi] = (rst || !re_v[gi] || (raddr_v[gi] == '0)) ? '0 :
                              (wb_we && (wb_waddr == raddr_v[gi]))       ? wb_wdata :
                                                                           regs[raddr_v[gi]];
      end
   endgenerate

   assign hi_o = rst ? '0 : (wb_hilo_we ? wb_hi : hi_q);
   assign lo_o = rst ? '0 : (wb_hilo_we ? wb_lo : lo_q);

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus queues expected values, a negedge
// monitor pops and compares them against the live outputs.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        wb_hilo_we;
   logic [31:0] wb_hi;
   logic [31:0] wb_lo;
   logic        re1;
   logic [4:0]  raddr1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   wb_regfile #(.REG_NUM(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .wb_hilo_we(wb_hilo_we), .wb_hi(wb_hi), .wb_lo(wb_lo),
      .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2), .hi_o(hi_o), .lo_o(lo_o)
   );

   typedef struct {
      string       name;
      int          sel;   // 0 rdata1, 1 rdata2, 2 hi_o, 3 lo_o
      logic [31:0] exp;
   } chk_t;

   chk_t q[$];
   int   checks = 0;
   int   errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required end of stimulus");
      $fatal(1, "watchdog expired");
   end

   // Monitor: outputs are combinational, so every queued expectation is due
   // at the negedge of the cycle in which it was issued.
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            chk_t        c;
            logic [31:0] got;
            c = q.pop_front();
            case (c.sel)
               0:       got = rdata1;
               1:       got = rdata2;
               2:       got = hi_o;
               default: got = lo_o;
            endcase
            checks++;
            if (got !== c.exp) begin
               errors++;
               $display("FAIL %s: got %08h required %08h", c.name, got, c.exp);
            end else begin
               $display("ok   %s: %08h", c.name, got);
            end
         end
      end
   end

   task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      q.push_back(c);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic hwe, input logic [31:0] hi, input logic [31:0] lo,
                        input logic r1, input logic [4:0] a1,
                        input logic r2, input logic [4:0] a2);
      wb_we = we; wb_waddr = wa; wb_wdata = wd;
      wb_hilo_we = hwe; wb_hi = hi; wb_lo = lo;
      re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, 5'd5, 32'h99, 1'b1, 32'h7, 32'h8, 1'b1, 5'd5, 1'b1, 5'd5);
      #1;
      expect_val("reset_rd1", 0, 32'h0);
      expect_val("reset_rd2", 1, 32'h0);
      expect_val("reset_hi", 2, 32'h0);
      expect_val("reset_lo", 3, 32'h0);
      step();
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
      expect_val("write_in_reset_lost", 0, 32'h0);
      expect_val("hilo_in_reset_lost", 2, 32'h0);

      // Write $5 and HI/LO, then clear them with an asynchronous reset pulse.
      step();
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'hAAAA, 32'hBBBB, 1'b1, 5'd5, 1'b0, 5'd0);
      expect_val("bypass_5", 0, 32'hDEADBEEF);
      expect_val("bypass_hi", 2, 32'hAAAA);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
      expect_val("stored_5", 0, 32'hDEADBEEF);
      expect_val("stored_lo", 3, 32'hBBBB);
      step();
      #1 rst = 1'b1;
      expect_val("async_rst_rd1", 0, 32'h0);
      expect_val("async_rst_hi", 2, 32'h0);
      expect_val("async_rst_lo", 3, 32'h0);
      #5 rst = 1'b0;
      step();
      expect_val("after_rst_5", 0, 32'h0);
      expect_val("after_rst_hi", 2, 32'h0);
      expect_val("after_rst_lo", 3, 32'h0);

      // Write then read on port 2.
      step();
      drive(1'b1, 5'd7, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7);
      expect_val("wr7_bypass", 1, 32'h12345678);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7);
      expect_val("rd7_n1", 1, 32'h12345678);
      step(); step(); step(); step();
      expect_val("rd7_n5", 1, 32'h12345678);

      // Same-cycle bypass, disabled port, back-to-back writes.
      step();
      drive(1'b1, 5'd3, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd7);
      expect_val("rd3_old", 0, 32'h1);
      expect_val("rd7_other_port", 1, 32'h12345678);
      step();
      drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
      expect_val("byp3_p1", 0, 32'hA5A5A5A5);
      expect_val("byp3_p2", 1, 32'hA5A5A5A5);
      step();
      drive(1'b1, 5'd3, 32'h5A5A5A5A, 1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3);
      expect_val("byp3_second", 0, 32'h5A5A5A5A);
      expect_val("re2_off", 1, 32'h0);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
      expect_val("last_wins_p1", 0, 32'h5A5A5A5A);
      expect_val("last_wins_p2", 1, 32'h5A5A5A5A);

      // $0 protection.
      step();
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
      expect_val("r0_same_p1", 0, 32'h0);
      expect_val("r0_same_p2", 1, 32'h0);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
      expect_val("r0_next_p1", 0, 32'h0);
      expect_val("r0_next_p2", 1, 32'h0);

      // HI/LO write, bypass and hold.
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h11, 32'h22, 1'b0, 5'd0, 1'b0, 5'd0);
      expect_val("hilo_byp_hi", 2, 32'h11);
      expect_val("hilo_byp_lo", 3, 32'h22);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h99, 32'h98, 1'b0, 5'd0, 1'b0, 5'd0);
      expect_val("hilo_hold_hi", 2, 32'h11);
      expect_val("hilo_hold_lo", 3, 32'h22);

      // Stall bubble after writing $9.
      step();
      drive(1'b1, 5'd9, 32'h55, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
      end
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd3);
      expect_val("stall_9", 0, 32'h55);
      expect_val("stall_3", 1, 32'h5A5A5A5A);
      expect_val("stall_hi", 2, 32'h11);
      expect_val("stall_lo", 3, 32'h22);

      step();
      step();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending checks, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
